// File: rtl/imm_gen_stage.sv
// imm_gen_stage
//
// Registered immediate-generation stage for the riscv_core decode path.
// The immediate is extracted combinationally from the incoming instruction
// for the selected format. It is then extended to XLEN and registered, with
// valid/ready handshakes on both the upstream and downstream sides.
//
// Build option: macro IMMGEN_SKID_EN
//   defined   - two-entry skid buffer; in_ready is a flop output.
//   undefined - single output register; in_ready = !out_valid || out_ready.
//
// Parameters:
//   XLEN   output width, 32 or 64
//   TAG_W  width of the sideband tag
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous discard of every held entry (highest priority)
//   in_valid     upstream presents an instruction
//   in_ready     stage can accept this cycle
//   in_instr     raw 32-bit instruction
//   in_imm_type  format select: I,S,B,U,J,CSR,SHAMT,reserved (0..7)
//   in_tag       sideband, passed through unchanged
//   out_valid    out_* payload valid
//   out_ready    downstream accepts
//   out_imm      extended immediate
//   out_tag      tag of the delivered entry
//   out_illegal  delivered entry used the reserved format
//
// Buffer states (skid build only):
//   state   | meaning
//   S_EMPTY | nothing held
//   S_ONE   | output register valid
//   S_FULL  | output register and skid register valid, accepts blocked
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    logic [31:0]     w_raw32;
    logic            w_sext;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;
    logic            w_accept;
    logic            w_out_xfer;

    // w_raw32 already holds the 32-bit result; w_sext picks how it widens
    // to XLEN, which is what gives U-type its bit 31 copy at XLEN=64.
    always_comb begin
        w_raw32   = '0;
        w_sext    = 1'b1;
        w_illegal = 1'b0;
        case (in_imm_type)
            3'b000: w_raw32 = {{20{in_instr[31]}}, in_instr[31:20]};
            3'b001: w_raw32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            3'b010: w_raw32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
            3'b011: w_raw32 = {in_instr[31:12], 12'b0};
            3'b100: w_raw32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
            3'b101: begin
                w_raw32 = {27'b0, in_instr[19:15]};
                w_sext  = 1'b0;
            end
            3'b110: begin
                w_raw32 = (XLEN == 64) ? {26'b0, in_instr[25:20]}
                                       : {27'b0, in_instr[24:20]};
                w_sext  = 1'b0;
            end
            default: begin
                w_raw32   = '0;
                w_sext    = 1'b0;
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_imm = w_sext ? XLEN'($signed(w_raw32)) : XLEN'(w_raw32);

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_illegal;

    assign w_out_xfer  = r_out_valid && out_ready;
    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_imm;
    assign out_tag     = r_out_tag;
    assign out_illegal = r_out_illegal;

`ifdef IMMGEN_SKID_EN

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_illegal;

    assign in_ready = r_in_ready;
    assign w_accept = in_valid && r_in_ready;

    // r_in_ready tracks "next state is not FULL" so it is ready as a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_EMPTY;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_out_imm      <= '0;
            r_out_tag      <= '0;
            r_out_illegal  <= 1'b0;
            r_skid_imm     <= '0;
            r_skid_tag     <= '0;
            r_skid_illegal <= 1'b0;
        end else if (flush) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_out_imm     <= w_imm;
                        r_out_tag     <= in_tag;
                        r_out_illegal <= w_illegal;
                        r_out_valid   <= 1'b1;
                        r_state       <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_out_xfer) begin
                        r_out_imm     <= w_imm;
                        r_out_tag     <= in_tag;
                        r_out_illegal <= w_illegal;
                    end else if (w_accept) begin
                        r_skid_imm     <= w_imm;
                        r_skid_tag     <= in_tag;
                        r_skid_illegal <= w_illegal;
                        r_state        <= S_FULL;
                        r_in_ready     <= 1'b0;
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_xfer) begin
                        r_out_imm     <= r_skid_imm;
                        r_out_tag     <= r_skid_tag;
                        r_out_illegal <= r_skid_illegal;
                        r_state       <= S_ONE;
                        r_in_ready    <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`else

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_imm     <= '0;
            r_out_tag     <= '0;
            r_out_illegal <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_imm     <= w_imm;
            r_out_tag     <= in_tag;
            r_out_illegal <= w_illegal;
            r_out_valid   <= 1'b1;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_type;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        rdy32, rdy64, ov32, ov64, ill32, ill64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;

    int n_pass  = 0;
    int n_total = 0;

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
        .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
        .out_tag(tag32), .out_illegal(ill32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
        .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
        .out_tag(tag64), .out_illegal(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: an ordered FIFO whose capacity depends on the build.
    typedef struct {
        logic [31:0] i32;
        logic [63:0] i64;
        logic [31:0] tag;
        logic        ill;
    } ent_t;

    ent_t q[$];

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] t,
                                            input int xlen);
        longint v;
        v = 0;
        case (t)
            3'd0: begin
                v = longint'(ins[31:20]);
                if (ins[31]) v -= 4096;
            end
            3'd1: begin
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (ins[31]) v -= 4096;
            end
            3'd2: begin
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (ins[31]) v -= 8192;
            end
            3'd3: begin
                v = longint'(ins[31:12]) * 4096;
                if (ins[31]) v -= 64'sh1_0000_0000;
            end
            3'd4: begin
                v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (ins[31]) v -= 2097152;
            end
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'h0, v[31:0]};
        return v;
    endfunction

    function automatic bit exp_in_ready();
`ifdef IMMGEN_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    // Advance one clock, updating the model with the transfers that happen
    // at this edge. Returns at posedge + 1.
    task automatic tick(output bit acc, output bit xfr);
        ent_t e;
        acc = rst_n && in_valid && exp_in_ready();
        xfr = rst_n && (q.size() != 0) && out_ready;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (xfr) q.delete(0);
            if (acc) begin
                e.i32 = ref_imm(in_instr, in_imm_type, 32) & 64'hFFFF_FFFF;
                e.i64 = ref_imm(in_instr, in_imm_type, 64);
                e.tag = in_tag;
                e.ill = (in_imm_type == 3'b111);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit a, x;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        in_imm_type = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) tick(a, x);
        n_total++;
        if ({ov32, ov64, ill32, ill64} !== 4'b0000) $display("FAIL reset_valid_illegal: got %b expected 0000", {ov32, ov64, ill32, ill64});
        else n_pass++;
        n_total++;
        if ({imm32, imm64, tag32, tag64} !== '0) $display("FAIL reset_payload: got imm32=%h imm64=%h tag32=%h tag64=%h expected zeros", imm32, imm64, tag32, tag64);
        else n_pass++;
        n_total++;
        if ({rdy32, rdy64} !== 2'b11) $display("FAIL reset_in_ready: got %b expected 11", {rdy32, rdy64});
        else n_pass++;
        #3 rst_n = 1'b1;
        tick(a, x);
        n_total++;
        if ({rdy32, rdy64, ov32, ov64} !== 4'b1100) $display("FAIL post_reset_ready: got %b expected 1100", {rdy32, rdy64, ov32, ov64});
        else n_pass++;
    endtask

    task automatic test_formats();
        logic [31:0] v_instr [5] = '{32'hFFF00093, 32'hFE000EE3, 32'h12345037, 32'h03F0D093, 32'h0123ABCD};
        logic [2:0]  v_type  [5] = '{3'd0, 3'd2, 3'd3, 3'd6, 3'd7};
        logic [31:0] v_exp32 [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h0000001F, 32'h0};
        logic [63:0] v_exp64 [5] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                                     64'h0000000012345000, 64'h3F, 64'h0};
        logic [31:0] v_tag   [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'hA5};
        bit a, x;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = v_instr[i]; in_imm_type = v_type[i]; in_tag = v_tag[i];
            tick(a, x);
            in_valid = 1'b0;
            n_total++;
            if ({ov32, ov64} !== 2'b11) $display("FAIL fmt%0d_valid: got %b expected 11", i, {ov32, ov64});
            else n_pass++;
            n_total++;
            if (imm32 !== v_exp32[i]) $display("FAIL fmt%0d_imm32: got %h expected %h", i, imm32, v_exp32[i]);
            else n_pass++;
            n_total++;
            if (imm64 !== v_exp64[i]) $display("FAIL fmt%0d_imm64: got %h expected %h", i, imm64, v_exp64[i]);
            else n_pass++;
            n_total++;
            if ({ill32, ill64, tag32, tag64} !== {{2{v_type[i] == 3'd7}}, v_tag[i], v_tag[i]})
                $display("FAIL fmt%0d_tag_illegal: got ill=%b%b tag=%h/%h expected ill=%b tag=%h",
                         i, ill32, ill64, tag32, tag64, v_type[i] == 3'd7, v_tag[i]);
            else n_pass++;
            tick(a, x);
            n_total++;
            if ({ov32, ov64} !== 2'b00) $display("FAIL fmt%0d_drain: got %b expected 00", i, {ov32, ov64});
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seen_tag [3];
        int          seen_cyc [3];
        int          n_seen;
        int          tag_next;
        bit          a, x;
        out_ready = 1'b0; in_imm_type = 3'd0; tag_next = 1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_tag = 32'(tag_next); in_instr = 32'(tag_next) << 20;
            tick(a, x);
            if (a) tag_next++;
            n_total++;
            if ({rdy32, rdy64} !== {2{exp_in_ready()}}) $display("FAIL stall%0d_in_ready: got %b expected %b", c, {rdy32, rdy64}, exp_in_ready());
            else n_pass++;
            n_total++;
            if (ov32 !== 1'b1 || tag32 !== 32'd1 || imm32 !== 32'd1) $display("FAIL stall%0d_hold: got v=%b tag=%h imm=%h expected v=1 tag=1 imm=1", c, ov32, tag32, imm32);
            else n_pass++;
        end
        n_total++;
        if (rdy32 !== 1'b0) $display("FAIL stall_full: got in_ready=%b expected 0", rdy32);
        else n_pass++;
        out_ready = 1'b1; n_seen = 0;
        for (int c = 0; c < 10 && n_seen < 3; c++) begin
            if (ov32 && out_ready) begin
                seen_tag[n_seen] = tag32; seen_cyc[n_seen] = c; n_seen++;
            end
            if (tag_next <= 3) begin
                in_valid = 1'b1; in_tag = 32'(tag_next); in_instr = 32'(tag_next) << 20;
            end else begin
                in_valid = 1'b0;
            end
            tick(a, x);
            if (a) tag_next++;
        end
        in_valid = 1'b0;
        n_total++;
        if (n_seen != 3) $display("FAIL b2b_count: got %0d deliveries expected 3", n_seen);
        else n_pass++;
        for (int k = 0; k < n_seen; k++) begin
            n_total++;
            if (seen_tag[k] !== 32'(k + 1) || (k > 0 && seen_cyc[k] != seen_cyc[k-1] + 1))
                $display("FAIL b2b_order%0d: got tag=%h cycle=%0d expected tag=%0d consecutive", k, seen_tag[k], seen_cyc[k], k + 1);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        bit a, x;
        out_ready = 1'b0; in_imm_type = 3'd1;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_tag = 32'(20 + c); in_instr = $urandom;
            tick(a, x);
        end
        n_total++;
        if (rdy32 !== 1'b0 || ov32 !== 1'b1) $display("FAIL flush_prefill: got ready=%b valid=%b expected 0 1", rdy32, ov32);
        else n_pass++;
        flush = 1'b1; in_valid = 1'b1; in_tag = 32'd9;
        tick(a, x);
        flush = 1'b0; in_valid = 1'b0;
        n_total++;
        if ({ov32, ov64, rdy32, rdy64} !== 4'b0011) $display("FAIL flush_state: got %b expected 0011", {ov32, ov64, rdy32, rdy64});
        else n_pass++;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(a, x);
            n_total++;
            if (ov32 !== 1'b0 || ov64 !== 1'b0) $display("FAIL flush_ghost%0d: got valid=%b%b tag=%h expected no entry", c, ov32, ov64, tag32);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midstream();
        bit a, x;
        out_ready = 1'b0; in_imm_type = 3'd4;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; in_tag = 32'(10 + c); in_instr = $urandom | 32'h8000_0000;
            tick(a, x);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({ov32, ov64, ill32, ill64} !== 4'b0000 || {imm32, imm64, tag32, tag64} !== '0)
            $display("FAIL async_reset_outputs: got v=%b%b imm=%h/%h tag=%h/%h expected zeros", ov32, ov64, imm32, imm64, tag32, tag64);
        else n_pass++;
        n_total++;
        if ({rdy32, rdy64} !== 2'b11) $display("FAIL async_reset_ready: got %b expected 11", {rdy32, rdy64});
        else n_pass++;
        q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        in_valid = 1'b1; in_tag = 32'd7; in_instr = 32'hFFF00093; in_imm_type = 3'd0; out_ready = 1'b1;
        tick(a, x);
        in_valid = 1'b0;
        n_total++;
        if (ov32 !== 1'b1 || tag32 !== 32'd7 || imm32 !== 32'hFFFFFFFF || imm64 !== 64'hFFFFFFFFFFFFFFFF)
            $display("FAIL post_reset_first: got v=%b tag=%h imm=%h/%h expected 1 7 all-ones", ov32, tag32, imm32, imm64);
        else n_pass++;
        tick(a, x);
    endtask

    task automatic test_random();
        bit a, x;
        for (int c = 0; c < 400; c++) begin
            n_total++;
            if (ov32 !== (q.size() != 0) || ov64 !== (q.size() != 0))
                $display("FAIL rnd%0d_valid: got %b%b expected %b", c, ov32, ov64, q.size() != 0);
            else n_pass++;
            n_total++;
            if (rdy32 !== exp_in_ready() || rdy64 !== exp_in_ready())
                $display("FAIL rnd%0d_in_ready: got %b%b expected %b", c, rdy32, rdy64, exp_in_ready());
            else n_pass++;
            if (q.size() != 0) begin
                n_total++;
                if ({imm32, tag32, ill32} !== {q[0].i32, q[0].tag, q[0].ill})
                    $display("FAIL rnd%0d_payload32: got imm=%h tag=%h ill=%b expected imm=%h tag=%h ill=%b",
                             c, imm32, tag32, ill32, q[0].i32, q[0].tag, q[0].ill);
                else n_pass++;
                n_total++;
                if ({imm64, tag64, ill64} !== {q[0].i64, q[0].tag, q[0].ill})
                    $display("FAIL rnd%0d_payload64: got imm=%h tag=%h ill=%b expected imm=%h tag=%h ill=%b",
                             c, imm64, tag64, ill64, q[0].i64, q[0].tag, q[0].ill);
                else n_pass++;
            end
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 24) == 0);
            in_instr    = $urandom;
            in_imm_type = 3'($urandom_range(0, 7));
            in_tag      = $urandom;
            tick(a, x);
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
